// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin arbiter sharing one I2C EEPROM read engine
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 11,
    parameter int TIMEOUT_CYCLES = 1_600_000,
    parameter int RECOVER_CYCLES = 1_600
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        timeout_err,
    output logic [7:0]                rd_data,
    output logic                      busy,
    output logic                      eng_read,
    output logic [ADDR_W-1:0]         eng_addr,
    input  logic                      eng_data_ready,
    input  logic [7:0]                eng_data
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ISSUE    = 3'd1;
    localparam logic [2:0] ST_WAIT     = 3'd2;
    localparam logic [2:0] ST_COMPLETE = 3'd3;
    localparam logic [2:0] ST_RECOVER  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] timeout_err_q, timeout_err_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               busy_q, busy_d;
    logic               eng_read_q, eng_read_d;
    logic [ADDR_W-1:0]  eng_addr_q, eng_addr_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [REC_W-1:0]   rec_q, rec_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;

    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [PTR_W-1:0]   rr_next;
    logic [WD_W-1:0]    wd_inc;
    int                 cand;

    // First pending requester at or above the round-robin pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!sel_found && req[cand[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign sel_addr = ADDR_W'(req_addr >> (int'(sel_idx) * ADDR_W));
    assign rr_next  = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign wd_inc   = (&wd_q) ? wd_q : wd_q + 1'b1;

    // Watchdog counts cycles since the read strobe (0 during ISSUE), so the
    // timeout pulse lands exactly TIMEOUT_CYCLES cycles after eng_read.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        done_d        = '0;
        timeout_err_d = '0;
        rd_data_d     = rd_data_q;
        eng_read_d    = 1'b0;
        eng_addr_d    = eng_addr_q;
        wd_d          = wd_q;
        rec_d         = rec_q;
        rr_d          = rr_q;
        owner_d       = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    grant_d    = NUM_REQ'(1) << sel_idx;
                    owner_d    = sel_idx;
                    eng_addr_d = sel_addr;
                    eng_read_d = 1'b1;
                    wd_d       = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d    = wd_inc;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_d = wd_inc;
                if (eng_data_ready) begin
                    rd_data_d = eng_data;
                    done_d    = grant_q;
                    state_d   = ST_COMPLETE;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = grant_q;
                    grant_d       = '0;
                    rr_d          = rr_next;
                    rec_d         = '0;
                    state_d       = ST_RECOVER;
                end
            end
            ST_COMPLETE: begin
                grant_d = '0;
                rr_d    = rr_next;
                state_d = ST_IDLE;
            end
            ST_RECOVER: begin
                if (rec_q == REC_W'(RECOVER_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    rec_d = rec_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            done_q        <= '0;
            timeout_err_q <= '0;
            rd_data_q     <= '0;
            busy_q        <= 1'b0;
            eng_read_q    <= 1'b0;
            eng_addr_q    <= '0;
            wd_q          <= '0;
            rec_q         <= '0;
            rr_q          <= '0;
            owner_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            rd_data_q     <= rd_data_d;
            busy_q        <= busy_d;
            eng_read_q    <= eng_read_d;
            eng_addr_q    <= eng_addr_d;
            wd_q          <= wd_d;
            rec_q         <= rec_d;
            rr_q          <= rr_d;
            owner_q       <= owner_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign rd_data     = rd_data_q;
    assign busy        = busy_q;
    assign eng_read    = eng_read_q;
    assign eng_addr    = eng_addr_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - directed self-checking bench for i2c_bus_arbiter
module tb_i2c_bus_arbiter;

    localparam int NR = 2;
    localparam int AW = 11;
    localparam int TO = 100;
    localparam int RC = 20;

    logic             clk;
    logic             reset_n;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    done;
    logic [NR-1:0]    timeout_err;
    logic [7:0]       rd_data;
    logic             busy;
    logic             eng_read;
    logic [AW-1:0]    eng_addr;
    logic             eng_data_ready;
    logic [7:0]       eng_data;

    int n_cmp = 0;
    int n_bad = 0;
    int n_reads = 0;

    i2c_bus_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT_CYCLES(TO), .RECOVER_CYCLES(RC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .grant(grant), .done(done), .timeout_err(timeout_err), .rd_data(rd_data),
        .busy(busy), .eng_read(eng_read), .eng_addr(eng_addr),
        .eng_data_ready(eng_data_ready), .eng_data(eng_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (eng_read) n_reads = n_reads + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig_hi(input int which);
        case (which)
            0:       return |done;
            1:       return |timeout_err;
            2:       return eng_read;
            default: return |grant;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int budget, input string tag, output int n);
        n = 0;
        while (!sig_hi(which) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(sig_hi(which)), 1);
    endtask

    task automatic respond(input int lat, input logic [7:0] d);
        repeat (lat) tick();
        eng_data_ready = 1'b1;
        eng_data       = d;
        tick();
        eng_data_ready = 1'b0;
        eng_data       = 8'h00;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        eng_data_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        int r0;
        logic [1:0] exp_g;
        logic [7:0] d;

        reset_n = 1'b0; req = '0; req_addr = '0; eng_data_ready = 1'b0; eng_data = 8'h00;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_eng_read", 32'(eng_read), 0);
        chk("rst_eng_addr", 32'(eng_addr), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_done_tmo", 32'({done, timeout_err}), 0);
        reset_n = 1'b1;
        tick();

        // single request
        r0 = n_reads;
        req = 2'b01; req_addr[0 +: AW] = 11'h010;
        tick();
        chk("t1_grant", 32'(grant), 1);
        chk("t1_eng_read", 32'(eng_read), 1);
        chk("t1_eng_addr", 32'(eng_addr), 32'h010);
        chk("t1_busy", 32'(busy), 1);
        tick();
        chk("t1_read_pulse", 32'(eng_read), 0);
        respond(48, 8'hA5);
        chk("t1_done", 32'(done), 1);
        chk("t1_rd_data", 32'(rd_data), 32'hA5);
        chk("t1_grant_held", 32'(grant), 1);
        req = 2'b00;
        tick();
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_grant_clr", 32'(grant), 0);
        chk("t1_done_pulse", 32'(done), 0);
        tick();
        chk("t1_rd_hold", 32'(rd_data), 32'hA5);
        chk("t1_one_read", 32'(n_reads - r0), 1);

        // simultaneous requests alternate
        do_reset();
        req_addr[0 +: AW] = 11'h111; req_addr[AW +: AW] = 11'h222; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            d = 8'(8'h40 + k);
            wait_sig(2, 10, "t2_issue_seen", n);
            chk("t2_grant", 32'(grant), 32'(exp_g));
            chk("t2_eng_addr", 32'(eng_addr), (exp_g == 2'b01) ? 32'h111 : 32'h222);
            respond(2, d);
            chk("t2_done", 32'(done), 32'(exp_g));
            chk("t2_rd_data", 32'(rd_data), 32'(d));
        end
        req = 2'b00;
        tick();
        tick();

        // timeout, recovery gap, then pending requester 1
        do_reset();
        req_addr[0 +: AW] = 11'h0AA; req_addr[AW +: AW] = 11'h1C3; req = 2'b01;
        tick();
        chk("t3_grant", 32'(grant), 1);
        req = 2'b11;
        wait_sig(1, 200, "t3_timeout_seen", n);
        chk("t3_latency", 32'(n), TO);
        chk("t3_tmo_owner", 32'(timeout_err), 1);
        chk("t3_grant_clr", 32'(grant), 0);
        chk("t3_busy", 32'(busy), 1);
        chk("t3_no_done", 32'(done), 0);
        tick();
        chk("t3_tmo_pulse", 32'(timeout_err), 0);
        wait_sig(3, 100, "t3_regrant_seen", n);
        chk("t3_recover_len", 32'(n), RC);
        chk("t3_next_grant", 32'(grant), 2);
        chk("t3_eng_addr", 32'(eng_addr), 32'h1C3);

        // data on the last watchdog cycle wins over timeout
        respond(TO - 1, 8'h3C);
        chk("t4_done", 32'(done), 2);
        chk("t4_rd_data", 32'(rd_data), 32'h3C);
        chk("t4_no_tmo", 32'(timeout_err), 0);
        req = 2'b00;
        tick();
        chk("t4_no_tmo_late", 32'(timeout_err), 0);
        chk("t4_idle", 32'(busy), 0);

        // requester 1 abandons; address change has no effect
        r0 = n_reads;
        req_addr[AW +: AW] = 11'h3AB; req = 2'b10;
        tick();
        chk("t5_grant", 32'(grant), 2);
        chk("t5_eng_addr", 32'(eng_addr), 32'h3AB);
        repeat (5) tick();
        req = 2'b00; req_addr[AW +: AW] = 11'h555;
        tick();
        chk("t5_addr_stable", 32'(eng_addr), 32'h3AB);
        chk("t5_grant_kept", 32'(grant), 2);
        respond(10, 8'h5A);
        chk("t5_done", 32'(done), 2);
        chk("t5_rd_data", 32'(rd_data), 32'h5A);
        repeat (4) tick();
        chk("t5_idle", 32'(busy), 0);
        chk("t5_one_read", 32'(n_reads - r0), 1);

        // async reset during WAIT
        req_addr[0 +: AW] = 11'h077; req = 2'b01;
        tick();
        chk("t6_issue", 32'(eng_read), 1);
        repeat (3) tick();
        chk("t6_in_wait", 32'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_eng_addr", 32'(eng_addr), 0);
        chk("t6_rst_rd_data", 32'(rd_data), 0);
        chk("t6_rst_pulses", 32'({eng_read, done, timeout_err}), 0);
        req = 2'b00;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        eng_data_ready = 1'b1; eng_data = 8'hFF;
        tick();
        eng_data_ready = 1'b0; eng_data = 8'h00;
        chk("t6_stray_rd", 32'(rd_data), 0);
        chk("t6_stray_busy", 32'(busy), 0);
        chk("t6_stray_done", 32'(done), 0);
        req = 2'b01;
        tick();
        chk("t6_grant", 32'(grant), 1);
        chk("t6_eng_read", 32'(eng_read), 1);
        chk("t6_eng_addr", 32'(eng_addr), 32'h077);
        respond(3, 8'h81);
        chk("t6_done", 32'(done), 1);
        chk("t6_rd_data", 32'(rd_data), 32'h81);
        req = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
